// File: rtl/riscv_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_bus_pkg
//  Description : Shared types and helpers for the core slave-bus arbiter.
//                - arb_state_e : arbiter FSM states
//                - bus_req_t   : one master's request fields at the bus width
//                - rr_wrap     : modulo-N increment used by the round-robin picker
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_bus_pkg;

  localparam int BUS_XLEN = 32;
  localparam int BUS_BE_W = BUS_XLEN / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                we;
    logic [BUS_XLEN-1:0] addr;
    logic [BUS_XLEN-1:0] wdata;
    logic [BUS_BE_W-1:0] be;
  } bus_req_t;

  // (base + step) mod n, valid for base < n and step <= n, so a single
  // conditional subtract is enough and no divider is inferred.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned step,
                                          input int unsigned n);
    int unsigned sum;
    sum = base + step;
    if (sum >= n) begin
      sum = sum - n;
    end
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_rr_arb
//  Description : Combinational round-robin picker. Searches last_gnt+1,
//                last_gnt+2, ... (modulo NMASTERS) and returns the first
//                active requester as both a one-hot vector and an index.
//  Ports       : req_i      - per-master request
//                last_gnt_i - index of the previously granted master
//                gnt_o      - one-hot winner (all zero when no request)
//                idx_o      - winner index (0 when no request)
//                valid_o    - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_rr_arb
  import riscv_bus_pkg::*;
#(
  parameter int NMASTERS = 2,
  parameter int IDX_W    = $clog2(NMASTERS)
) (
  input  logic [NMASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]    last_gnt_i,
  output logic [NMASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                valid_o
);

  logic [IDX_W-1:0] w_cand;

  // Walk the search order from lowest to highest priority so that the
  // highest-priority requester is the last one written into idx_o.
  always_comb begin
    w_cand = '0;
    idx_o  = '0;
    for (int unsigned i = NMASTERS; i >= 1; i--) begin
      w_cand = IDX_W'(rr_wrap(32'(last_gnt_i), i, NMASTERS));
      if (req_i[w_cand]) begin
        idx_o = w_cand;
      end
    end
  end

  assign valid_o = |req_i;

  always_comb begin
    gnt_o = '0;
    if (valid_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_bus_arb
//  Description : Round-robin arbiter sharing the core slave bus between
//                NMASTERS requesters. Grants one transaction at a time,
//                forwards the winner's fields to the slave side, counts a
//                fixed slave latency and returns a response pulse to the owner.
//  Ports       : clk, rst_n    - clock / asynchronous active-low reset
//                m_req_i       - per-master request
//                m_we_i        - per-master write enable
//                m_addr_i      - per-master address   (master i at [i*XLEN +: XLEN])
//                m_wdata_i     - per-master write data (same packing)
//                m_be_i        - per-master byte enables (master i at [i*XLEN/8 +: XLEN/8])
//                m_gnt_o       - one-hot grant, same cycle as acceptance
//                m_rvalid_o    - one-hot response / write-ack pulse to owner
//                m_rdata_o     - response data (qualified by m_rvalid_o)
//                s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o - slave request
//                s_rdata_i     - read data from the bus controller mux
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_bus_arb
  import riscv_bus_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NMASTERS = 2,
  parameter int RD_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NMASTERS-1:0]          m_req_i,
  input  logic [NMASTERS-1:0]          m_we_i,
  input  logic [NMASTERS*XLEN-1:0]     m_addr_i,
  input  logic [NMASTERS*XLEN-1:0]     m_wdata_i,
  input  logic [NMASTERS*XLEN/8-1:0]   m_be_i,
  output logic [NMASTERS-1:0]          m_gnt_o,
  output logic [NMASTERS-1:0]          m_rvalid_o,
  output logic [XLEN-1:0]              m_rdata_o,
  output logic                         s_req_o,
  output logic                         s_we_o,
  output logic [XLEN-1:0]              s_addr_o,
  output logic [XLEN-1:0]              s_wdata_o,
  output logic [XLEN/8-1:0]            s_be_o,
  input  logic [XLEN-1:0]              s_rdata_i
);

  localparam int IDX_W = $clog2(NMASTERS);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam int BE_W  = XLEN / 8;

  arb_state_e       state_q;
  logic [LAT_W-1:0] lat_cnt_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] last_gnt_q;

  logic [NMASTERS-1:0] w_arb_gnt;
  logic [IDX_W-1:0]    w_arb_idx;
  logic                w_arb_valid;
  logic                w_take;
  logic                w_done;

  logic [XLEN-1:0] w_addr  [NMASTERS];
  logic [XLEN-1:0] w_wdata [NMASTERS];
  logic [BE_W-1:0] w_be    [NMASTERS];

  for (genvar g = 0; g < NMASTERS; g++) begin : g_unpack
    assign w_addr[g]  = m_addr_i[g*XLEN +: XLEN];
    assign w_wdata[g] = m_wdata_i[g*XLEN +: XLEN];
    assign w_be[g]    = m_be_i[g*BE_W +: BE_W];
  end

  riscv_rr_arb #(
    .NMASTERS (NMASTERS),
    .IDX_W    (IDX_W)
  ) u_rr_arb (
    .req_i      (m_req_i),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (w_arb_gnt),
    .idx_o      (w_arb_idx),
    .valid_o    (w_arb_valid)
  );

  // A request is accepted only while idle; grant and slave request share it.
  assign w_take = (state_q == IDLE) && w_arb_valid;
  assign w_done = (state_q == WAIT) && (lat_cnt_q == LAT_W'(RD_LAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      owner_q    <= '0;
      // Pointing at the last master makes master 0 the first winner.
      last_gnt_q <= IDX_W'(NMASTERS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (w_arb_valid) begin
            owner_q    <= w_arb_idx;
            last_gnt_q <= w_arb_idx;
            lat_cnt_q  <= LAT_W'(1);
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (w_done) begin
            lat_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_gnt_o   = w_take ? w_arb_gnt : '0;
  assign s_req_o   = w_take;
  assign s_we_o    = w_take & m_we_i[w_arb_idx];
  assign s_be_o    = w_take ? w_be[w_arb_idx] : '0;
  assign s_addr_o  = w_addr[w_arb_idx];
  assign s_wdata_o = w_wdata[w_arb_idx];

  always_comb begin
    m_rvalid_o = '0;
    if (w_done) begin
      m_rvalid_o[owner_q] = 1'b1;
    end
  end

  assign m_rdata_o = w_done ? s_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_riscv_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_bus_arb
//  Description : Directed self-checking bench for riscv_bus_arb. Three
//                instances: A (2 masters, latency 1), B (2 masters,
//                latency 3), C (3 masters, latency 1). Inputs change on the
//                falling edge and outputs are sampled 1 ns later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_bus_arb;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  // ---------------- instance A: NMASTERS=2, RD_LAT=1 ----------------
  logic [1:0]  a_req, a_we, a_gnt, a_rvalid;
  logic [63:0] a_addr, a_wdata;
  logic [7:0]  a_be;
  logic [31:0] a_rdata, a_saddr, a_swdata, a_srdata;
  logic        a_sreq, a_swe;
  logic [3:0]  a_sbe;

  // ---------------- instance B: NMASTERS=2, RD_LAT=3 ----------------
  logic [1:0]  b_req, b_we, b_gnt, b_rvalid;
  logic [63:0] b_addr, b_wdata;
  logic [7:0]  b_be;
  logic [31:0] b_rdata, b_saddr, b_swdata, b_srdata;
  logic        b_sreq, b_swe;
  logic [3:0]  b_sbe;

  // ---------------- instance C: NMASTERS=3, RD_LAT=1 ----------------
  logic [2:0]  c_req, c_we, c_gnt, c_rvalid;
  logic [95:0] c_addr, c_wdata;
  logic [11:0] c_be;
  logic [31:0] c_rdata, c_saddr, c_swdata, c_srdata;
  logic        c_sreq, c_swe;
  logic [3:0]  c_sbe;

  riscv_bus_arb #(.XLEN(32), .NMASTERS(2), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(a_req), .m_we_i(a_we), .m_addr_i(a_addr), .m_wdata_i(a_wdata), .m_be_i(a_be),
    .m_gnt_o(a_gnt), .m_rvalid_o(a_rvalid), .m_rdata_o(a_rdata),
    .s_req_o(a_sreq), .s_we_o(a_swe), .s_addr_o(a_saddr), .s_wdata_o(a_swdata),
    .s_be_o(a_sbe), .s_rdata_i(a_srdata)
  );

  riscv_bus_arb #(.XLEN(32), .NMASTERS(2), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(b_req), .m_we_i(b_we), .m_addr_i(b_addr), .m_wdata_i(b_wdata), .m_be_i(b_be),
    .m_gnt_o(b_gnt), .m_rvalid_o(b_rvalid), .m_rdata_o(b_rdata),
    .s_req_o(b_sreq), .s_we_o(b_swe), .s_addr_o(b_saddr), .s_wdata_o(b_swdata),
    .s_be_o(b_sbe), .s_rdata_i(b_srdata)
  );

  riscv_bus_arb #(.XLEN(32), .NMASTERS(3), .RD_LAT(1)) u_c (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(c_req), .m_we_i(c_we), .m_addr_i(c_addr), .m_wdata_i(c_wdata), .m_be_i(c_be),
    .m_gnt_o(c_gnt), .m_rvalid_o(c_rvalid), .m_rdata_o(c_rdata),
    .s_req_o(c_sreq), .s_we_o(c_swe), .s_addr_o(c_saddr), .s_wdata_o(c_swdata),
    .s_be_o(c_sbe), .s_rdata_i(c_srdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_be = '0; a_srdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_be = '0; b_srdata = '0;
    c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0; c_be = '0; c_srdata = '0;
  endtask

  // Leaves the bench on a falling edge with reset just released: that
  // falling edge is "cycle 0" of the following test.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int grants;

  initial begin
    n_checks = 0;
    n_errors = 0;
    grants   = 0;
    rst_n    = 1'b1;
    clear_inputs();

    // ---------------- reset state ----------------
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_gnt",    a_gnt,    0);
    check_eq("rst_rvalid", a_rvalid, 0);
    check_eq("rst_sreq",   a_sreq,   0);
    check_eq("rst_swe",    a_swe,    0);
    check_eq("rst_sbe",    a_sbe,    0);

    // ---------------- test 1: both request, RD_LAT=1 ----------------
    do_reset();
    a_addr = {32'h0000_0200, 32'h0000_0100};
    a_req  = 2'b11;
    #1;
    check_eq("t1_c0_gnt",   a_gnt,   2'b01);
    check_eq("t1_c0_sreq",  a_sreq,  1);
    check_eq("t1_c0_saddr", a_saddr, 32'h0000_0100);
    @(negedge clk); #1;
    check_eq("t1_c1_gnt",    a_gnt,    2'b00);
    check_eq("t1_c1_rvalid", a_rvalid, 2'b01);
    @(negedge clk); #1;
    check_eq("t1_c2_gnt",    a_gnt,    2'b10);
    check_eq("t1_c2_saddr",  a_saddr,  32'h0000_0200);
    check_eq("t1_c2_rvalid", a_rvalid, 2'b00);
    @(negedge clk);
    a_req = 2'b00;
    #1;
    check_eq("t1_c3_rvalid", a_rvalid, 2'b10);

    // ---------------- test 3: continuous requests, 20 cycles ----------------
    do_reset();
    a_req = 2'b11;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (k % 2 == 1) check_eq("t3_gnt_odd", a_gnt, 2'b00);
      else if ((k / 2) % 2 == 0) check_eq("t3_gnt_m0", a_gnt, 2'b01);
      else check_eq("t3_gnt_m1", a_gnt, 2'b10);
      if (a_gnt != 2'b00) grants++;
      @(negedge clk);
    end
    a_req = 2'b00;
    check_eq("t3_total", grants, 10);

    // ---------------- test 4: master 0 write ----------------
    do_reset();
    a_we    = 2'b01;
    a_addr  = {32'h0, 32'h0000_0010};
    a_wdata = {32'h0, 32'h1234_5678};
    a_be    = 8'b0000_0011;
    a_req   = 2'b01;
    #1;
    check_eq("t4_gnt",   a_gnt,    2'b01);
    check_eq("t4_swe",   a_swe,    1);
    check_eq("t4_sbe",   a_sbe,    4'b0011);
    check_eq("t4_saddr", a_saddr,  32'h0000_0010);
    check_eq("t4_sdata", a_swdata, 32'h1234_5678);
    @(negedge clk);
    a_req = 2'b00;
    #1;
    check_eq("t4_ack", a_rvalid, 2'b01);
    @(negedge clk); #1;
    check_eq("t4_ack_once", a_rvalid, 2'b00);

    // ---------------- test 2: master 1 read, RD_LAT=3 ----------------
    do_reset();
    b_srdata = 32'hDEAD_BEEF;
    b_addr   = {32'h1000_0004, 32'h0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
    end
    b_req = 2'b10;
    #1;
    check_eq("t2_c5_gnt",   b_gnt,   2'b10);
    check_eq("t2_c5_saddr", b_saddr, 32'h1000_0004);
    check_eq("t2_c5_swe",   b_swe,   0);
    @(negedge clk);
    b_req = 2'b00;
    for (int k = 6; k <= 9; k++) begin
      #1;
      if (k == 8) begin
        check_eq("t2_c8_rvalid", b_rvalid, 2'b10);
        check_eq("t2_c8_rdata",  b_rdata,  32'hDEAD_BEEF);
      end else begin
        check_eq("t2_rvalid_quiet", b_rvalid, 2'b00);
      end
      @(negedge clk);
    end

    // ---------------- test 5: reset during WAIT ----------------
    do_reset();
    b_req = 2'b01;
    #1;
    check_eq("t5_gnt0", b_gnt, 2'b01);
    @(negedge clk);
    b_req = 2'b00;
    #1;
    check_eq("t5_c1_rvalid", b_rvalid, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_rvalid", b_rvalid, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("t5_no_rvalid", b_rvalid, 2'b00);
      @(negedge clk);
    end
    b_req = 2'b11;
    #1;
    check_eq("t5_restart_gnt", b_gnt, 2'b01);
    @(negedge clk);
    b_req = 2'b00;

    // ---------------- test 6: three masters, wrap ----------------
    do_reset();
    c_req = 3'b110;
    #1;
    check_eq("t6_gnt_m1", c_gnt, 3'b010);
    @(negedge clk); #1;
    check_eq("t6_rv_m1", c_rvalid, 3'b010);
    @(negedge clk); #1;
    check_eq("t6_gnt_m2", c_gnt, 3'b100);
    @(negedge clk); #1;
    check_eq("t6_rv_m2", c_rvalid, 3'b100);
    @(negedge clk);
    c_req = 3'b111;
    #1;
    check_eq("t6_gnt_wrap", c_gnt, 3'b001);
    @(negedge clk);
    c_req = 3'b000;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
